// File: rtl/datamem_pipe_if.sv
// Request/response bundle for datamem_pipe: valid/ready request channel,
// always-accepted response channel, plus init and parity status.
interface datamem_pipe_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 14
) ();
    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [WIDTH/8-1:0] req_be;
    logic [AW-1:0]      req_addr;
    logic [WIDTH-1:0]   req_wdata;
    logic               rsp_valid;
    logic [WIDTH-1:0]   rsp_rdata;
    logic               init_done;
    logic               par_err;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, init_done, par_err
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, init_done, par_err
    );
endinterface

// File: rtl/datamem_pipe.sv
// Pipelined byte-writable data memory with a zeroing sweep after reset and a
// READ_LAT-deep read pipeline. Optional per-byte parity: DATAMEM_PARITY_EN.
module datamem_pipe #(
    parameter int WIDTH    = 16,
    parameter int AW       = 14,
    parameter int READ_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    datamem_pipe_if.slave bus
);

    localparam int NB    = WIDTH / 8;
    localparam int DEPTH = 2 ** AW;
`ifdef DATAMEM_PARITY_EN
    localparam int MW = WIDTH + NB;
`else
    localparam int MW = WIDTH;
`endif

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        cnt_q, cnt_d;
    logic [MW-1:0]        mem_q [DEPTH];

    logic                 run_s;
    logic                 rd_hs_s;
    logic                 wr_en_s;
    logic [AW-1:0]        wr_addr_s;
    logic [WIDTH-1:0]     wr_data_s;
    logic [NB-1:0]        wr_be_s;

    logic [READ_LAT-1:0]  vld_q;
    logic [MW-1:0]        data_q [READ_LAT];
    logic [READ_LAT-1:0]  pv_s;
    logic [MW-1:0]        pd_s   [READ_LAT];

`ifdef DATAMEM_PARITY_EN
    logic [NB-1:0]        wr_par_s;
    logic                 perr_q;

    function automatic logic [NB-1:0] lane_parity(input logic [WIDTH-1:0] d);
        logic [NB-1:0] p;
        p = {NB{1'b0}};
        for (int i = 0; i < NB; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction
`endif

    assign run_s   = (state_q == ST_RUN);
    assign rd_hs_s = run_s & bus.req_valid & ~bus.req_we;

    // Sweep FSM: INIT walks cnt over every word, then RUN forever.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + {{(AW-1){1'b0}}, 1'b1};
                if (cnt_q == {AW{1'b1}}) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
                cnt_d   = cnt_q;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = {AW{1'b0}};
            end
        endcase
    end

    // FSM state and sweep counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= {AW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Single write port shared by the zeroing sweep and host writes.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = bus.req_addr;
        wr_data_s = bus.req_wdata;
        wr_be_s   = bus.req_be;
        if (!run_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = cnt_q;
            wr_data_s = {WIDTH{1'b0}};
            wr_be_s   = {NB{1'b1}};
        end else if (bus.req_valid && bus.req_we) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

`ifdef DATAMEM_PARITY_EN
    assign wr_par_s = lane_parity(wr_data_s);
`endif

    // Memory array, byte-lane masked; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be_s[i]) begin
                    mem_q[wr_addr_s][8*i +: 8] <= wr_data_s[8*i +: 8];
`ifdef DATAMEM_PARITY_EN
                    mem_q[wr_addr_s][WIDTH+i] <= wr_par_s[i];
`endif
                end
            end
        end
    end

    // Inputs to each pipeline stage: stage 0 takes the array read.
    always_comb begin
        pv_s[0] = rd_hs_s;
        pd_s[0] = mem_q[bus.req_addr];
        for (int i = 1; i < READ_LAT; i++) begin
            pv_s[i] = vld_q[i-1];
            pd_s[i] = data_q[i-1];
        end
    end

    // Read pipeline; data only advances with valid so the tail holds its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= {READ_LAT{1'b0}};
            for (int i = 0; i < READ_LAT; i++) begin
                data_q[i] <= {MW{1'b0}};
            end
        end else begin
            for (int i = 0; i < READ_LAT; i++) begin
                vld_q[i] <= pv_s[i];
                if (pv_s[i]) begin
                    data_q[i] <= pd_s[i];
                end
            end
        end
    end

`ifdef DATAMEM_PARITY_EN
    // Parity check on the word entering the output stage; zero when no response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= pv_s[READ_LAT-1] &&
                      (pd_s[READ_LAT-1][MW-1:WIDTH] !=
                       lane_parity(pd_s[READ_LAT-1][WIDTH-1:0]));
        end
    end
    assign bus.par_err = perr_q;
`else
    assign bus.par_err = 1'b0;
`endif

    assign bus.req_ready = run_s;
    assign bus.init_done = run_s;
    assign bus.rsp_valid = vld_q[READ_LAT-1];
    assign bus.rsp_rdata = data_q[READ_LAT-1][WIDTH-1:0];

endmodule

// File: tb/tb_datamem_pipe.sv
// Self-checking bench for datamem_pipe: directed scenarios plus random traffic
// compared against a word-array model with a due-cycle response queue.
module tb_datamem_pipe;

    localparam int WIDTH = 16;
    localparam int AW    = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    datamem_pipe_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    datamem_pipe #(.WIDTH(WIDTH), .AW(AW), .READ_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        logic [15:0] data;
        logic        perr;
    } rsp_t;

    int          total     = 0;
    int          bad       = 0;
    int          edge_n    = 0;
    int          init_cnt  = 0;
    int          flip_addr = -1;
    logic        ready_m   = 1'b0;
    logic [15:0] last_data = 16'h0000;
    logic [15:0] ref_mem [DEPTH];
    rsp_t        exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        rsp_t e;
        logic ev;
        ev = (exp_q.size() > 0) && (exp_q[0].due == edge_n);
        chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, ev});
        chk("req_ready", {31'd0, bus.req_ready}, {31'd0, ready_m});
        chk("init_done", {31'd0, bus.init_done}, {31'd0, ready_m});
        if (ev) begin
            e = exp_q.pop_front();
            last_data = e.data;
            chk("rsp_rdata", {16'd0, bus.rsp_rdata}, {16'd0, e.data});
            chk("par_err",   {31'd0, bus.par_err},   {31'd0, e.perr});
        end else begin
            chk("rsp_hold",     {16'd0, bus.rsp_rdata}, {16'd0, last_data});
            chk("par_err_idle", {31'd0, bus.par_err},   32'd0);
        end
    endtask

    // One clock: drive at negedge, update model at posedge, check at next negedge.
    task automatic cycle(input logic v, input logic we, input logic [1:0] be,
                         input logic [3:0] a, input logic [15:0] d);
        rsp_t e;
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_be    = be;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(posedge clk);
        edge_n++;
        if (ready_m) begin
            if (v && we) begin
                for (int i = 0; i < 2; i++) begin
                    if (be[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
                end
            end else if (v) begin
                e.due  = edge_n + LAT - 1;
                e.data = ref_mem[a];
                e.perr = (int'(a) == flip_addr);
                exp_q.push_back(e);
            end
        end else begin
            init_cnt++;
            if (init_cnt == DEPTH) ready_m = 1'b1;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom),
                  4'($urandom), 16'($urandom));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_init_done", {31'd0, bus.init_done}, 32'd0);
        chk("rst_par_err",   {31'd0, bus.par_err},   32'd0);
        exp_q.delete();
        last_data = 16'h0000;
        ready_m   = 1'b0;
        init_cnt  = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_be    = 2'b00;
        bus.req_addr  = 4'd0;
        bus.req_wdata = 16'h0000;

        // Reset, then a sweep cut short by a second reset; requests during INIT are ignored.
        do_reset();
        rand_cycles(5);
        do_reset();
        rand_cycles(DEPTH);

        // Every word reads back as zero after the sweep.
        for (int a = 0; a < DEPTH; a++) cycle(1'b1, 1'b0, 2'b11, 4'(a), 16'h0000);
        idle(LAT + 1);

        // Byte-lane merge: expect 0xAB34.
        cycle(1'b1, 1'b1, 2'b11, 4'd3, 16'hABCD);
        cycle(1'b1, 1'b1, 2'b01, 4'd3, 16'h1234);
        cycle(1'b1, 1'b0, 2'b00, 4'd3, 16'h0000);
        idle(LAT + 1);
        chk("merge_ab34", {16'd0, last_data}, 32'h0000AB34);

        // Preload and four back-to-back reads.
        for (int a = 0; a < 4; a++) cycle(1'b1, 1'b1, 2'b11, 4'(a), 16'h0010 + 16'(a));
        for (int a = 0; a < 4; a++) cycle(1'b1, 1'b0, 2'b00, 4'(a), 16'h0000);
        idle(LAT + 1);

        // Read right after write, reads with be=0, and a be=0 write no-op.
        cycle(1'b1, 1'b1, 2'b11, 4'd5, 16'h5555);
        cycle(1'b1, 1'b0, 2'b00, 4'd5, 16'h0000);
        cycle(1'b1, 1'b1, 2'b00, 4'd5, 16'hDEAD);
        cycle(1'b1, 1'b0, 2'b00, 4'd5, 16'h0000);
        idle(LAT + 1);
        chk("be0_noop", {16'd0, last_data}, 32'h00005555);

        // Reset with two reads in flight: they vanish and the sweep re-zeroes addr 7.
        cycle(1'b1, 1'b1, 2'b11, 4'd7, 16'hFFFF);
        cycle(1'b1, 1'b0, 2'b00, 4'd7, 16'h0000);
        cycle(1'b1, 1'b0, 2'b00, 4'd7, 16'h0000);
        do_reset();
        idle(DEPTH + LAT);
        cycle(1'b1, 1'b0, 2'b00, 4'd7, 16'h0000);
        idle(LAT + 1);
        chk("addr7_cleared", {16'd0, last_data}, 32'h00000000);

`ifdef DATAMEM_PARITY_EN
        cycle(1'b1, 1'b1, 2'b11, 4'd9, 16'h00FF);
        force dut.mem_q[9] = 18'h100FF;
        flip_addr = 9;
        cycle(1'b1, 1'b0, 2'b00, 4'd9, 16'h0000);
        flip_addr = -1;
        cycle(1'b1, 1'b0, 2'b00, 4'd8, 16'h0000);
        idle(LAT + 1);
        release dut.mem_q[9];
        cycle(1'b1, 1'b1, 2'b11, 4'd9, 16'h0000);
`endif

        rand_cycles(400);
        idle(LAT + 1);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
